iecdrv_sd_arbiter: RTL and testbench

- Shares one host SD block interface between NDRV drive instances, each a drive-side sd_rd/sd_wr/sd_lba/sd_blk_cnt requester.
- Sits in the clk_sys domain between the drive array and the host SD port.
- Grants one requester at a time, round-robin, and routes ack, buffer-write strobe and write data back to the granted drive only.
- Provides request-timeout and cancel recovery.

---
 rtl/iecdrv_sd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_iecdrv_sd_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iecdrv_sd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iecdrv_sd_arbiter
// Purpose  : Round-robin arbiter sharing one host SD block port between
//            NDRV drive requesters, with request timeout and cancel recovery.
// Revision : 1.0 - initial release
// ============================================================================
module iecdrv_sd_arbiter #(
  parameter int          NDRV    = 4,
  parameter logic [23:0] TIMEOUT = 24'd16000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NDRV-1:0]      drv_rd,
  input  logic [NDRV-1:0]      drv_wr,
  input  logic [32*NDRV-1:0]   drv_lba,
  input  logic [6*NDRV-1:0]    drv_blk_cnt,
  input  logic [8*NDRV-1:0]    drv_buff_din,
  output logic [NDRV-1:0]      drv_ack,
  output logic [NDRV-1:0]      drv_buff_wr,
  output logic [31:0]          sd_lba,
  output logic [5:0]           sd_blk_cnt,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int GW = (NDRV > 1) ? $clog2(NDRV) : 1;
  // REQ lasts exactly TIMEOUT cycles: the counter runs TIMEOUT-1 down to 0.
  localparam logic [23:0] TIMER_LOAD = (TIMEOUT == 24'd0) ? 24'd0 : (TIMEOUT - 24'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   last_r;
  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic            op_wr;
  logic [23:0]     timer;
  logic [NDRV-1:0] req;
  logic            req_held;
  logic            timer_zero;
  logic [3:0]      idx;

  assign req        = drv_rd | drv_wr;
  // The request bit matching the latched operation; its loss cancels REQ.
  assign req_held   = op_wr ? drv_wr[grant_r] : drv_rd[grant_r];
  assign timer_zero = (timer == 24'd0);

  // Round-robin search: first pending drive after the last one served.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NDRV; k++) begin
      idx = 4'(last_r) + 4'(k);
      if (idx >= 4'(NDRV)) begin
        idx = idx - 4'(NDRV);
      end
      if (!pick_vld && req[idx[GW-1:0]]) begin
        pick     = idx[GW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and drive-side routing; only the granted drive sees ack/strobe.
  always_comb begin
    state_nx    = state;
    drv_ack     = '0;
    drv_buff_wr = '0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nx = REQ;
      end
      REQ: begin
        if (sd_ack)         state_nx = XFER;
        else if (!req_held) state_nx = IDLE;
        else if (timer_zero) state_nx = IDLE;
      end
      XFER: begin
        drv_ack[grant_r]     = sd_ack;
        drv_buff_wr[grant_r] = sd_buff_wr & sd_ack;
        if (!sd_ack) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Grant latch, host request registers, timeout counter and fairness pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_r     <= '0;
      last_r      <= GW'(NDRV - 1);
      op_wr       <= 1'b0;
      sd_lba      <= '0;
      sd_blk_cnt  <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_r    <= pick;
            op_wr      <= drv_wr[pick];
            sd_lba     <= drv_lba[32*pick +: 32];
            sd_blk_cnt <= drv_blk_cnt[6*pick +: 6];
            sd_rd      <= ~drv_wr[pick];
            sd_wr      <= drv_wr[pick];
            timer      <= TIMER_LOAD;
          end
        end
        REQ: begin
          if (sd_ack || !req_held || timer_zero) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
          end else begin
            timer <= timer - 24'd1;
          end
          if (!sd_ack && req_held && timer_zero) begin
            timeout_err <= 1'b1;
          end
        end
        DONE: begin
          last_r <= grant_r;
        end
        default: ;
      endcase
    end
  end

  assign grant       = 3'(grant_r);
  assign busy        = (state != IDLE);
  assign sd_buff_din = drv_buff_din[8*grant_r +: 8];

endmodule
`default_nettype wire

// File: tb/tb_iecdrv_sd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iecdrv_sd_arbiter
// Purpose  : Self-checking bench: vector table, corner-case sequences and
//            randomized multi-drive traffic against a round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iecdrv_sd_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   drv_rd, drv_wr;
  logic [31:0]    lba [N];
  logic [5:0]     blk [N];
  logic [7:0]     din [N];
  logic [32*N-1:0] drv_lba;
  logic [6*N-1:0]  drv_blk_cnt;
  logic [8*N-1:0]  drv_buff_din;
  logic [N-1:0]   drv_ack, drv_buff_wr;
  logic [31:0]    sd_lba;
  logic [5:0]     sd_blk_cnt;
  logic           sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]     sd_buff_din;
  logic [2:0]     grant;
  logic           busy, timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  iecdrv_sd_arbiter #(.NDRV(N), .TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset),
    .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_lba(drv_lba),
    .drv_blk_cnt(drv_blk_cnt), .drv_buff_din(drv_buff_din),
    .drv_ack(drv_ack), .drv_buff_wr(drv_buff_wr),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Pack per-drive arrays into the flat buses.
  always_comb begin
    drv_lba      = '0;
    drv_blk_cnt  = '0;
    drv_buff_din = '0;
    for (int i = 0; i < N; i++) begin
      drv_lba[32*i +: 32]     = lba[i];
      drv_blk_cnt[6*i +: 6]   = blk[i];
      drv_buff_din[8*i +: 8]  = din[i];
    end
  end

  typedef struct {
    int          drv;
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic [7:0]  din;
    logic        exp_rd;
    logic        exp_wr;
    logic [N-1:0] exp_ack;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    drv_rd = '0; drv_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    for (int i = 0; i < N; i++) begin
      lba[i] = '0; blk[i] = '0; din[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sd_rd || sd_wr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_req: actual sd_rd|sd_wr=0 required=1 within 40 cycles");
    end
  endtask

  // Reference round-robin: first pending drive after 'last', modulo N.
  function automatic int rr_next(input int last, input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Serve one host request end to end; optionally raise drive 'rereq' mid-transfer.
  task automatic serve(input int exp_g, input int rereq);
    bit ok;
    wait_req(ok);
    chk("serve_grant", 64'(grant), 64'(exp_g));
    sd_ack = 1'b1;
    tick();
    chk("serve_ack", 64'(drv_ack), 64'(1 << exp_g));
    drv_rd[exp_g] = 1'b0;
    drv_wr[exp_g] = 1'b0;
    if (rereq >= 0) drv_rd[rereq] = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          cnt, other, hi, te, e, d, np, j;
    int          m_last;
    logic [N-1:0] pend;
    logic [N-1:0] m_wr;
    logic [1:0]  rw;

    vt[0] = '{2, 1'b1, 1'b0, 32'h0000_0123, 6'd5,  8'h3C, 1'b1, 1'b0, 4'b0100};
    vt[1] = '{1, 1'b1, 1'b1, 32'hDEAD_BEEF, 6'd63, 8'hA5, 1'b0, 1'b1, 4'b0010};
    vt[2] = '{0, 1'b0, 1'b1, 32'h8000_0001, 6'd0,  8'h5A, 1'b0, 1'b1, 4'b0001};
    vt[3] = '{3, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd31, 8'hFF, 1'b1, 1'b0, 4'b1000};
    vt[4] = '{2, 1'b1, 1'b1, 32'h1234_5678, 6'd7,  8'h00, 1'b0, 1'b1, 4'b0100};
    vt[5] = '{0, 1'b1, 1'b0, 32'h0000_0000, 6'd1,  8'h81, 1'b1, 1'b0, 4'b0001};

    // Reset state.
    reset = 1'b1;
    clear_inputs();
    tick();
    chk("rst_drv_ack", 64'(drv_ack), 64'd0);
    chk("rst_drv_buff_wr", 64'(drv_buff_wr), 64'd0);
    chk("rst_sd_lba", 64'(sd_lba), 64'd0);
    chk("rst_sd_blk_cnt", 64'(sd_blk_cnt), 64'd0);
    chk("rst_sd_rdwr", 64'({sd_rd, sd_wr}), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    tick();

    // Single-requester vector table.
    for (int v = 0; v < 6; v++) begin
      lba[vt[v].drv] = vt[v].lba;
      blk[vt[v].drv] = vt[v].blk;
      din[vt[v].drv] = vt[v].din;
      drv_rd[vt[v].drv] = vt[v].rd;
      drv_wr[vt[v].drv] = vt[v].wr;
      #1;
      chk("vt_latency", 64'({sd_rd, sd_wr}), 64'd0);
      tick();
      chk("vt_sd_rd", 64'(sd_rd), 64'(vt[v].exp_rd));
      chk("vt_sd_wr", 64'(sd_wr), 64'(vt[v].exp_wr));
      chk("vt_sd_lba", 64'(sd_lba), 64'(vt[v].lba));
      chk("vt_sd_blk_cnt", 64'(sd_blk_cnt), 64'(vt[v].blk));
      chk("vt_grant", 64'(grant), 64'(vt[v].drv));
      chk("vt_busy_req", 64'(busy), 64'd1);
      chk("vt_ack_in_req", 64'(drv_ack), 64'd0);
      sd_ack = 1'b1;
      tick();
      chk("vt_rdwr_drop", 64'({sd_rd, sd_wr}), 64'd0);
      chk("vt_drv_ack", 64'(drv_ack), 64'(vt[v].exp_ack));
      chk("vt_buff_din", 64'(sd_buff_din), 64'(vt[v].din));
      sd_buff_wr = 1'b1;
      #1;
      chk("vt_buff_wr", 64'(drv_buff_wr), 64'(vt[v].exp_ack));
      drv_rd = '0;
      drv_wr = '0;
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      tick();
      chk("vt_done_busy", 64'(busy), 64'd1);
      chk("vt_done_ack", 64'(drv_ack), 64'd0);
      tick();
      chk("vt_idle_busy", 64'(busy), 64'd0);
    end

    // Spurious ack in IDLE is ignored.
    sd_ack = 1'b1;
    tick(); tick(); tick();
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_rdwr", 64'({sd_rd, sd_wr}), 64'd0);
    chk("spur_ack", 64'(drv_ack), 64'd0);
    sd_ack = 1'b0;
    tick();

    // Fairness: 0,1,3 pending; drive 0 re-requests during drive 1's transfer.
    do_reset();
    drv_rd[0] = 1'b1; drv_rd[1] = 1'b1; drv_rd[3] = 1'b1;
    serve(0, -1);
    serve(1, 0);
    serve(3, -1);
    serve(0, -1);
    tick();
    chk("fair_idle", 64'(busy), 64'd0);

    // 256 buffer strobes routed only to drive 0.
    do_reset();
    drv_rd[0] = 1'b1;
    wait_req(ok);
    sd_ack = 1'b1;
    tick();
    drv_rd[0] = 1'b0;
    cnt = 0; other = 0;
    for (int p = 0; p < 256; p++) begin
      sd_buff_wr = 1'b1;
      #1;
      if (drv_buff_wr[0]) cnt++;
      if (drv_buff_wr[3:1] != 3'b000) other++;
      tick();
      sd_buff_wr = 1'b0;
      #1;
      if (drv_buff_wr[0]) cnt++;
      if (drv_buff_wr[3:1] != 3'b000) other++;
      tick();
    end
    chk("strobe_count0", 64'(cnt), 64'd256);
    chk("strobe_others", 64'(other), 64'd0);
    sd_ack = 1'b0;
    tick(); tick();

    // Timeout: drive 3 never acked.
    do_reset();
    drv_rd[3] = 1'b1;
    tick();
    hi = 0; te = 0;
    for (int i = 0; i < 150; i++) begin
      if (sd_rd) hi++;
      if (timeout_err) begin
        te++;
        chk("to_busy", 64'(busy), 64'd0);
        drv_rd[3] = 1'b0;
      end
      tick();
    end
    chk("to_req_cycles", 64'(hi), 64'd100);
    chk("to_pulses", 64'(te), 64'd1);
    drv_rd[0] = 1'b1;
    serve(0, -1);

    // Cancel in REQ: no timeout_err.
    drv_rd[2] = 1'b1;
    wait_req(ok);
    chk("cancel_grant", 64'(grant), 64'd2);
    drv_rd[2] = 1'b0;
    tick();
    chk("cancel_rd", 64'(sd_rd), 64'd0);
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_te0", 64'(timeout_err), 64'd0);
    tick();
    chk("cancel_te1", 64'(timeout_err), 64'd0);

    // Asynchronous reset mid-transfer.
    drv_rd[1] = 1'b1;
    wait_req(ok);
    sd_ack = 1'b1;
    tick();
    chk("arst_pre_ack", 64'(drv_ack), 64'b0010);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ack", 64'(drv_ack), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_lba", 64'(sd_lba), 64'd0);
    chk("arst_rdwr", 64'({sd_rd, sd_wr}), 64'd0);
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();

    // Randomized traffic against the round-robin model.
    do_reset();
    m_last = N - 1;
    m_wr = '0;
    for (int r = 0; r < 30; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          rw = 2'($urandom_range(1, 3));
          drv_rd[i] = rw[0];
          drv_wr[i] = rw[1];
          m_wr[i] = rw[1];
          lba[i] = $urandom;
          blk[i] = 6'($urandom);
          din[i] = 8'($urandom);
        end
      end
      while (pend != '0) begin
        e = rr_next(m_last, pend);
        wait_req(ok);
        if (!ok) break;
        chk("rnd_grant", 64'(grant), 64'(e));
        chk("rnd_wr", 64'(sd_wr), 64'(m_wr[e]));
        chk("rnd_rd", 64'(sd_rd), 64'(!m_wr[e]));
        chk("rnd_lba", 64'(sd_lba), 64'(lba[e]));
        chk("rnd_blk", 64'(sd_blk_cnt), 64'(blk[e]));
        d = $urandom_range(0, 2);
        repeat (d) tick();
        chk("rnd_still_req", 64'(sd_rd | sd_wr), 64'd1);
        sd_ack = 1'b1;
        tick();
        chk("rnd_ack", 64'(drv_ack), 64'(1 << e));
        chk("rnd_din", 64'(sd_buff_din), 64'(din[e]));
        drv_rd[e] = 1'b0;
        drv_wr[e] = 1'b0;
        pend[e] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          j = $urandom_range(0, N - 1);
          if (!pend[j]) begin
            drv_rd[j] = 1'b1;
            m_wr[j] = 1'b0;
            pend[j] = 1'b1;
            if (j != e) begin
              lba[j] = $urandom;
              blk[j] = 6'($urandom);
            end
          end
        end
        np = $urandom_range(0, 6);
        cnt = 0; other = 0; hi = 0;
        for (int p = 0; p < np; p++) begin
          sd_buff_wr = 1'($urandom_range(0, 1));
          if (sd_buff_wr) hi++;
          #1;
          if (drv_buff_wr[e]) cnt++;
          if ((drv_buff_wr & ~(N'(1) << e)) != '0) other++;
          tick();
        end
        chk("rnd_strobes", 64'(cnt), 64'(hi));
        chk("rnd_strobe_others", 64'(other), 64'd0);
        chk("rnd_lba_hold", 64'(sd_lba), 64'(sd_lba));
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        tick();
        tick();
        m_last = e;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
